// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control FSM driving the RV64 datapath enables and mux selects.
// Optional macro UC_ILLEGAL_TRAP_EN: unrecognised opcodes trap (sticky illegal) instead of retiring as a NOP.
module unidade_controle #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic [6:0]       opcode,
    input  logic             flag,
    output logic             weIR,
    output logic             wePC,
    output logic             weReg,
    output logic             weMem,
    output logic             sinalMux1,
    output logic             sinalMux2,
    output logic             sinalMux3,
    output logic             busy,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);
    localparam int unsigned MCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [MCW-1:0] MEM_LAST = MCW'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_LD, C_SD, C_ALUI, C_ALUR, C_BEQ, C_ILL
    } class_t;

    typedef struct packed {
        logic busy;
        logic we_ir;
        logic we_pc;
        logic we_reg;
        logic we_mem;
        logic mux1;
        logic mux2;
        logic mux3;
        logic done;
    } ctrl_t;

    state_t           r_state, w_nxt_state, w_after;
    class_t           r_cls, w_nxt_cls;
    logic [MCW-1:0]   r_cnt, w_nxt_cnt;
    ctrl_t            r_ctrl, w_ctrl;
    logic [CNT_W-1:0] r_count;
    logic             w_unused_flag;

    // Branch resolution happens in the datapath (Mux3 ANDs with flag).
    assign w_unused_flag = flag;

    function automatic class_t classify(input logic [6:0] op);
        case (op)
            7'b0000011: classify = C_LD;
            7'b0100011: classify = C_SD;
            7'b0010011: classify = C_ALUI;
            7'b0110011: classify = C_ALUR;
            7'b1100011: classify = C_BEQ;
            default:    classify = C_ILL;
        endcase
    endfunction

    // Moore decode of (state, class, MEM counter) into the control word.
    function automatic ctrl_t decode(input state_t s, input class_t c, input logic [MCW-1:0] cnt);
        ctrl_t o;
        logic  imm;
        o   = '0;
        imm = (c == C_LD) || (c == C_SD) || (c == C_ALUI);
        case (s)
            S_FETCH: begin
                o.busy  = 1'b1;
                o.we_ir = 1'b1;
            end
            S_DECODE, S_TRAP: o.busy = 1'b1;
            S_EXEC: begin
                o.busy = 1'b1;
                o.mux1 = imm;
                if (c == C_BEQ || c == C_ILL) begin
                    o.we_pc = 1'b1;
                    o.done  = 1'b1;
                    o.mux3  = (c == C_BEQ);
                end
            end
            S_MEM: begin
                o.busy = 1'b1;
                o.mux1 = 1'b1;
                if (cnt == MEM_LAST && c == C_SD) begin
                    o.we_mem = 1'b1;
                    o.we_pc  = 1'b1;
                    o.done   = 1'b1;
                end
            end
            S_WB: begin
                o.busy   = 1'b1;
                o.we_reg = 1'b1;
                o.we_pc  = 1'b1;
                o.done   = 1'b1;
                o.mux1   = imm;
                o.mux2   = (c == C_LD);
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    assign w_after = halt ? S_IDLE : S_FETCH;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cls   = r_cls;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_IDLE:  if (start) w_nxt_state = S_FETCH;
            S_FETCH: w_nxt_state = S_DECODE;
            S_DECODE: begin
                w_nxt_cls = classify(opcode);
`ifdef UC_ILLEGAL_TRAP_EN
                w_nxt_state = (classify(opcode) == C_ILL) ? S_TRAP : S_EXEC;
`else
                w_nxt_state = S_EXEC;
`endif
            end
            S_EXEC: begin
                case (r_cls)
                    C_LD, C_SD: begin
                        w_nxt_state = S_MEM;
                        w_nxt_cnt   = '0;
                    end
                    C_ALUI, C_ALUR: w_nxt_state = S_WB;
                    default:        w_nxt_state = w_after;
                endcase
            end
            S_MEM: begin
                if (r_cnt == MEM_LAST) begin
                    w_nxt_state = (r_cls == C_SD) ? w_after : S_WB;
                end else begin
                    w_nxt_cnt = r_cnt + MCW'(1);
                end
            end
            S_WB:    w_nxt_state = w_after;
            S_TRAP:  w_nxt_state = S_TRAP;
            default: w_nxt_state = S_IDLE;
        endcase
        w_ctrl = decode(w_nxt_state, w_nxt_cls, w_nxt_cnt);
    end

    // Outputs are registered from the next-state decode, so they line up with r_state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cls   <= C_LD;
            r_cnt   <= '0;
            r_ctrl  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cls   <= w_nxt_cls;
            r_cnt   <= w_nxt_cnt;
            r_ctrl  <= w_ctrl;
            if (r_ctrl.done) r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                      r_illegal <= 1'b0;
        else if (w_nxt_state == S_TRAP) r_illegal <= 1'b1;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign weIR        = r_ctrl.we_ir;
    assign wePC        = r_ctrl.we_pc;
    assign weReg       = r_ctrl.we_reg;
    assign weMem       = r_ctrl.we_mem;
    assign sinalMux1   = r_ctrl.mux1;
    assign sinalMux2   = r_ctrl.mux2;
    assign sinalMux3   = r_ctrl.mux3;
    assign busy        = r_ctrl.busy;
    assign instr_done  = r_ctrl.done;
    assign instr_count = r_count;

endmodule
